// File: rtl/table_fsm_pkg.sv
// Shared types and default constants for the two-byte sequence transmitter FSM.
package table_fsm_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] DEF_BYTE0 = 8'h0D;
  localparam logic [DATA_W-1:0] DEF_BYTE1 = 8'h0A;

  typedef enum logic [2:0] {
    st_init      = 3'd0,
    st_load0     = 3'd1,
    st_waitload0 = 3'd2,
    st_waitsend0 = 3'd3,
    st_load1     = 3'd4,
    st_waitload1 = 3'd5,
    st_waitsend1 = 3'd6,
    st_finish    = 3'd7
  } state_t;

endpackage

// File: rtl/table_fsm.sv
// Sends BYTE0 then BYTE1 to a transmitter on each start request, pacing on txempty.
// Outputs are flops loaded from the decode of the next state, so they track state exactly.
module table_fsm
  import table_fsm_pkg::*;
#(
  parameter logic [DATA_W-1:0] BYTE0 = DEF_BYTE0,
  parameter logic [DATA_W-1:0] BYTE1 = DEF_BYTE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              txempty,
  output logic              done,
  output logic [DATA_W-1:0] txdata,
  output logic              ldtxdata
);

  state_t            state;
  state_t            state_nxt;
  logic              done_nxt;
  logic              ldtxdata_nxt;
  logic [DATA_W-1:0] txdata_nxt;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= st_init;
      done     <= 1'b0;
      ldtxdata <= 1'b0;
      txdata   <= '0;
    end else begin
      state    <= state_nxt;
      done     <= done_nxt;
      ldtxdata <= ldtxdata_nxt;
      txdata   <= txdata_nxt;
    end
  end

  // Next-state logic, then output decode of the state being entered
  always_comb begin
    state_nxt    = state;
    done_nxt     = 1'b0;
    ldtxdata_nxt = 1'b0;
    txdata_nxt   = '0;

    case (state)
      st_init:      if (start) state_nxt = st_load0;
      st_load0:     state_nxt = st_waitload0;
      st_waitload0: state_nxt = st_waitsend0;
      st_waitsend0: if (txempty) state_nxt = st_load1;
      st_load1:     state_nxt = st_waitload1;
      st_waitload1: state_nxt = st_waitsend1;
      st_waitsend1: if (txempty) state_nxt = st_finish;
      st_finish:    state_nxt = st_init;
      default:      state_nxt = st_init;
    endcase

    case (state_nxt)
      st_load0: begin
        ldtxdata_nxt = 1'b1;
        txdata_nxt   = BYTE0;
      end
      st_waitload0, st_waitsend0: txdata_nxt = BYTE0;
      st_load1: begin
        ldtxdata_nxt = 1'b1;
        txdata_nxt   = BYTE1;
      end
      st_waitload1, st_waitsend1: txdata_nxt = BYTE1;
      st_finish:    done_nxt = 1'b1;
      default: begin
        done_nxt     = 1'b0;
        ldtxdata_nxt = 1'b0;
        txdata_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_table_fsm.sv
// Directed plus random bench for table_fsm against a position-in-sequence reference model.
module tb_table_fsm;
  import table_fsm_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       txempty = 1'b0;
  logic       done;
  logic [7:0] txdata;
  logic       ldtxdata;

  int n_checks = 0;
  int n_fails  = 0;

  // Model: position in the 7-step sequence, 0 = idle
  int         pos = 0;
  state_t     pos_state [8] = '{st_init, st_load0, st_waitload0, st_waitsend0,
                                st_load1, st_waitload1, st_waitsend1, st_finish};

  table_fsm dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .txempty  (txempty),
    .done     (done),
    .txdata   (txdata),
    .ldtxdata (ldtxdata)
  );

  always #5 clk = ~clk;

  function automatic int model_next(input int p, input logic r, input logic s, input logic t);
    if (r) return 0;
    if (p == 0) return s ? 1 : 0;
    if (p == 3 || p == 6) return t ? p + 1 : p;
    if (p == 7) return 0;
    return p + 1;
  endfunction

  task automatic check_outputs(input string tag);
    logic       e_done;
    logic       e_ld;
    logic [7:0] e_tx;
    e_done = (pos == 7);
    e_ld   = (pos == 1 || pos == 4);
    e_tx   = (pos >= 1 && pos <= 3) ? 8'h0D : (pos >= 4 && pos <= 6) ? 8'h0A : 8'h00;

    n_checks++;
    assert (dut.state === pos_state[pos]) else begin
      n_fails++;
      $error("FAIL %s state: observed %s expected %s", tag, dut.state.name(), pos_state[pos].name());
    end
    n_checks++;
    assert (done === e_done) else begin
      n_fails++;
      $error("FAIL %s done: observed %b expected %b", tag, done, e_done);
    end
    n_checks++;
    assert (ldtxdata === e_ld) else begin
      n_fails++;
      $error("FAIL %s ldtxdata: observed %b expected %b", tag, ldtxdata, e_ld);
    end
    n_checks++;
    assert (txdata === e_tx) else begin
      n_fails++;
      $error("FAIL %s txdata: observed %h expected %h", tag, txdata, e_tx);
    end
  endtask

  // Drive inputs on the falling edge, advance model at the rising edge, sample 1 time unit later
  task automatic tick(input logic r, input logic s, input logic t, input string tag);
    @(negedge clk);
    reset   = r;
    start   = s;
    txempty = t;
    @(posedge clk);
    pos = model_next(pos, r, s, t);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int ld_count;
    int done_count;
    int done_at;

    // Reset then idle
    tick(1'b1, 1'b0, 1'b0, "reset");
    tick(1'b0, 1'b0, 1'b0, "idle");

    // First byte, waitsend0 held while txempty low
    tick(1'b0, 1'b1, 1'b0, "load0");
    tick(1'b0, 1'b0, 1'b0, "waitload0");
    tick(1'b0, 1'b1, 1'b0, "waitsend0_a");
    tick(1'b0, 1'b0, 1'b0, "waitsend0_b");
    tick(1'b0, 1'b0, 1'b0, "waitsend0_c");

    // Second byte, waitsend1 held while txempty low
    tick(1'b0, 1'b0, 1'b1, "load1");
    tick(1'b0, 1'b0, 1'b1, "waitload1");
    tick(1'b0, 1'b0, 1'b0, "waitsend1_a");
    tick(1'b0, 1'b0, 1'b0, "waitsend1_b");
    tick(1'b0, 1'b0, 1'b1, "finish");
    tick(1'b0, 1'b0, 1'b0, "back_init");

    // start and txempty held: done after 7 cycles, two load strobes, restart after finish
    ld_count = 0;
    done_at  = 0;
    for (int i = 1; i <= 9; i++) begin
      tick(1'b0, 1'b1, 1'b1, "streaming");
      if (i <= 7 && ldtxdata === 1'b1) ld_count++;
      if (done === 1'b1 && done_at == 0) done_at = i;
    end
    n_checks++;
    assert (ld_count == 2) else begin
      n_fails++;
      $error("FAIL ld_pulses: observed %0d expected 2", ld_count);
    end
    n_checks++;
    assert (done_at == 7) else begin
      n_fails++;
      $error("FAIL done_latency: observed %0d expected 7", done_at);
    end

    // Abort in waitsend0 with reset taking priority over start and txempty
    tick(1'b1, 1'b0, 1'b0, "pre_abort_reset");
    tick(1'b0, 1'b1, 1'b0, "abort_load0");
    tick(1'b0, 1'b0, 1'b0, "abort_waitload0");
    tick(1'b0, 1'b0, 1'b0, "abort_waitsend0");
    tick(1'b1, 1'b1, 1'b1, "abort_reset");
    done_count = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b0, "abort_after");
      if (done === 1'b1) done_count++;
    end
    n_checks++;
    assert (done_count == 0) else begin
      n_fails++;
      $error("FAIL abort_no_done: observed %0d done pulses expected 0", done_count);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 1), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
